// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single memory port.
// m0 = core, m1 = debug/DMA. One transaction in flight at a time:
// IDLE grants, BUSY drives the memory, RESP returns the completion.
// Optional feature macro: ARB_RR_EN (round-robin tie break; default is
// fixed priority with port 0 winning ties).
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t              state, state_nxt;
  logic                port_q;     // 0 = m0 owns the transaction, 1 = m1
  logic [15:0]         cnt;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                any_req;
  logic                winner;

  assign any_req = m0_req | m1_req;

`ifdef ARB_RR_EN
  logic prefer_m1;

  // Round-robin pointer: after each grant the other port is preferred on a tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      prefer_m1 <= 1'b0;
    else if (state == IDLE && any_req)
      prefer_m1 <= ~winner;
  end

  assign winner = m1_req & (~m0_req | prefer_m1);
`else
  assign winner = m1_req & ~m0_req;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic and combinational grant (grant is suppressed while in reset).
  always_comb begin
    state_nxt = state;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && reset) begin
          m0_gnt    = ~winner;
          m1_gnt    = winner;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack || cnt == CNT_LAST)
          state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction datapath: latch the winner's fields, count wait cycles, capture the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_q    <= 1'b0;
      cnt       <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            port_q    <= winner;
            mem_we    <= winner ? m1_we    : m0_we;
            mem_addr  <= winner ? m1_addr  : m0_addr;
            mem_wdata <= winner ? m1_wdata : m0_wdata;
            mem_wstrb <= winner ? m1_wstrb : m0_wstrb;
            cnt       <= '0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            rdata_q <= mem_we ? '0 : mem_rdata;
            err_q   <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory request and per-port completion outputs.
  always_comb begin
    mem_req   = (state == BUSY);
    m0_rvalid = (state == RESP) && !port_q;
    m1_rvalid = (state == RESP) &&  port_q;
    m0_rdata  = m0_rvalid ? rdata_q : '0;
    m1_rdata  = m1_rvalid ? rdata_q : '0;
    m0_err    = m0_rvalid & err_q;
    m1_err    = m1_rvalid & err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants and
// completions into queues, independent monitors pop and compare them.
module tb_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  int   exp_gnt[$];
  rsp_t exp_rsp[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected required=none", name);
  endtask

  // Grant monitor.
  always @(negedge clk) begin
    if (reset && (m0_gnt || m1_gnt)) begin
      chk("gnt_onehot", 32'(m0_gnt & m1_gnt), 32'd0);
      if (exp_gnt.size() == 0) fail_now("gnt_unexpected");
      else chk("gnt_port", 32'(m1_gnt), 32'(exp_gnt.pop_front()));
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (m0_rvalid || m1_rvalid) begin
      rsp_t e;
      chk("rvalid_onehot", 32'(m0_rvalid & m1_rvalid), 32'd0);
      if (exp_rsp.size() == 0) fail_now("rvalid_unexpected");
      else begin
        e = exp_rsp.pop_front();
        chk("rsp_port", 32'(m1_rvalid), 32'(e.port));
        chk("rsp_rdata", m1_rvalid ? m1_rdata : m0_rdata, e.data);
        chk("rsp_err", 32'(m1_rvalid ? m1_err : m0_err), 32'(e.err));
        chk("idle_port_rdata", m1_rvalid ? m0_rdata : m1_rdata, 32'd0);
        chk("idle_port_err", 32'(m1_rvalid ? m0_err : m1_err), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction from a single requester; ack_after = 0 means no ack (timeout).
  task automatic do_txn(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int ack_after, input logic [31:0] mrdata);
    rsp_t r;
    int   busy_n;
    busy_n = (ack_after == 0) ? int'(TO) : ack_after;
    r.port = port;
    r.err  = (ack_after == 0);
    r.data = (ack_after == 0 || we) ? 32'd0 : mrdata;
    exp_gnt.push_back(port);
    exp_rsp.push_back(r);
    if (port == 0) begin
      m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end else begin
      m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    end
    @(negedge clk);
    chk("gnt_same_cycle", 32'(port == 0 ? m0_gnt : m1_gnt), 32'd1);
    step();
    m0_req = 0; m1_req = 0;
    for (int i = 0; i < busy_n; i++) begin
      mem_ack   = (ack_after != 0) && (i == busy_n - 1);
      mem_rdata = mrdata;
      @(negedge clk);
      chk("mem_req_busy", 32'(mem_req), 32'd1);
      chk("mem_addr", mem_addr, addr);
      chk("mem_we", 32'(mem_we), 32'(we));
      chk("mem_wdata", mem_wdata, wdata);
      chk("mem_wstrb", 32'(mem_wstrb), 32'(wstrb));
      step();
      mem_ack = 0;
    end
    @(negedge clk);
    chk("rvalid_latency", 32'(port == 0 ? m0_rvalid : m1_rvalid), 32'd1);
    chk("mem_req_resp", 32'(mem_req), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    fail_now("watchdog_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a request pending to show gnt is held off.
    m0_req = 1;
    #2;
    chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    m0_req = 0;
    @(negedge clk);
    reset = 1;
    step();
    @(negedge clk);
    chk("post_rst_no_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    step();

    // Single read, ack after 2 BUSY cycles.
    do_txn(0, 1'b0, 32'h100, 32'h0, 4'h0, 2, 32'hDEADBEEF);

    // Stray ack in IDLE, then a write whose ack carries non-zero rdata.
    mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("stray_ack_mem_req", 32'(mem_req), 32'd0);
    step();
    mem_ack = 0;
    @(negedge clk);
    chk("stray_ack_no_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    chk("stray_ack_mem_req2", 32'(mem_req), 32'd0);
    step();
    do_txn(0, 1'b1, 32'h40, 32'h12345678, 4'hF, 2, 32'hFFFFFFFF);

    // Timeout: m1 write, no ack.
    do_txn(1, 1'b1, 32'h80, 32'hCAFE0001, 4'h3, 0, 32'h0);

    // Single-cycle ack read from m1.
    do_txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 1, 32'h0BADF00D);

    // Reset asserted while BUSY: transaction abandoned.
    exp_gnt.push_back(0);
    m0_req = 1; m0_we = 0; m0_addr = 32'h200;
    step();
    m0_req = 0;
    @(negedge clk);
    chk("busy_before_rst", 32'(mem_req), 32'd1);
    #2;
    reset = 0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    chk("rst_mid_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    reset = 1;
    step();
    do_txn(1, 1'b0, 32'h300, 32'h0, 4'h0, 1, 32'h55AA55AA);

    // Contention from a fresh reset so the round-robin pointer starts at port 0.
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    step();
    m0_we = 0; m1_we = 0; m0_addr = 32'h1000; m1_addr = 32'h2000;
    m0_req = 1; m1_req = 1;
    for (int t = 0; t < 4; t++) begin
      rsp_t r;
`ifdef ARB_RR_EN
      r.port = t % 2;
`else
      r.port = 0;
`endif
      r.data = 32'hA0 + 32'(t);
      r.err  = 1'b0;
      exp_gnt.push_back(r.port);
      exp_rsp.push_back(r);
      step();
      mem_ack = 1; mem_rdata = r.data;
      @(negedge clk);
      chk("contention_addr", mem_addr, r.port == 0 ? 32'h1000 : 32'h2000);
      step();
      mem_ack = 0;
      if (t == 3) begin
        m0_req = 0; m1_req = 0;
      end
      step();
    end
    step();
    step();

    chk("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);
    chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
